deserializador: RTL and testbench
=================================

Name: deserializador

Overview:
Serial-to-parallel receiver for the serial stream produced by the shift-register block's S_OUT in PUSH mode. It collects WIDTH bits, MSB-first or LSB-first, into a word and presents the word on a single-entry valid/ready output buffer. It sits downstream of the shift register on the serial link and reports framing and overflow errors.

Parameters:
WIDTH, 4, word width in bits (WIDTH >= 2).

Ports:
CLK  input  1  clock; all logic on posedge.
RESET_L  input  1  synchronous active-low reset.
ENB  input  1  receive enable; low freezes the receive path.
S_IN  input  1  serial data bit.
S_VALID  input  1  S_IN carries a bit this cycle.
S_START  input  1  qualifies the first bit of a word; only meaningful with S_VALID.
DIR  input  1  0 = MSB-first, 1 = LSB-first; sampled on the first bit of each word.
CLR  input  1  clears OVERFLOW.
Q  output  WIDTH  received word.
Q_VALID  output  1  Q holds an unconsumed word.
Q_READY  input  1  consumer accepts Q when Q_VALID & Q_READY.
OVERFLOW  output  1  sticky; a completed word was dropped.
FRAME_ERR  output  1  one-cycle pulse; S_START arrived mid-word.

Behaviour:
- Reset (RESET_L=0 at posedge):
  - Q=0, Q_VALID=0, OVERFLOW=0, FRAME_ERR=0.
  - Internal shift register SR=0, bit counter CNT=0, state IDLE.
  - Reset overrides all other inputs, including mid-word; the partial word is discarded.
- States: IDLE, RECV.
  - IDLE: bits are ignored unless S_VALID & S_START & ENB.
  - On such a bit: latch DIR into DIR_LAT, shift the bit in, set CNT=1, go to RECV.
- Bit accept in RECV: requires ENB & S_VALID.
  - DIR_LAT=0: SR <= {SR[WIDTH-2:0], S_IN}.
  - DIR_LAT=1: SR <= {S_IN, SR[WIDTH-1:1]}.
  - CNT increments on each accepted bit.
  - DIR changes mid-word are ignored.
- Word completion: the accepted bit makes CNT reach WIDTH.
  - The completed word includes that bit.
  - CNT returns to 0 and the state stays in RECV, so streaming continues.
  - The next word's first bit needs no S_START; DIR is re-latched on it.
- Output buffer:
  - On completion, if Q_VALID=0 or Q_READY=1: Q <= word and Q_VALID <= 1 at the same edge.
  - Latency: Q_VALID is visible in the cycle after the last bit is sampled.
  - On completion with Q_VALID=1 and Q_READY=0: the word is dropped, OVERFLOW <= 1, and Q is unchanged.
  - With no completion: Q_VALID & Q_READY gives Q_VALID <= 0, and Q is unchanged.
  - Q is stable whenever Q_VALID=1 and Q_READY=0.
- OVERFLOW:
  - Sticky until CLR=1.
  - If CLR coincides with a new overflow, set wins.
- Resync: S_VALID & S_START & ENB in RECV with CNT != 0:
  - FRAME_ERR=1 for exactly one cycle.
  - The partial word is discarded.
  - The bit is treated as the first bit of a new word (CNT=1, DIR re-latched).
  - S_START with CNT=0 in RECV is legal and gives no error.
- ENB=0:
  - S_VALID, S_START and DIR are ignored; SR, CNT and state hold.
  - The output handshake (Q_VALID clear on Q_READY) and CLR still operate.
- FRAME_ERR is 0 in every cycle not described above.

Decomposition:
- definitions.v additions:
  - `ST_IDLE, `ST_RECV state encodings.
  - `DIR_MSB_FIRST = 0, `DIR_LSB_FIRST = 1.
- One natural sub-module: buffer_salida, the single-entry valid/ready word buffer that owns Q, Q_VALID and OVERFLOW. Its inputs are the word, a completion strobe, Q_READY and CLR.
- The top level holds the FSM, SR, CNT and DIR_LAT.

Test Plan:
1. Reset behaviour. Hold RESET_L=0 for 2 cycles with S_VALID=1, S_START=1, S_IN=1, then release with S_VALID=0.
   -> Q=0, Q_VALID=0, OVERFLOW=0, FRAME_ERR=0 throughout.
2. MSB-first word and handshake. WIDTH=4, DIR=0, S_START on the first bit, bits 1,0,1,1 on consecutive cycles, Q_READY=0.
   -> Q=4'b1011 and Q_VALID=1 the cycle after the 4th bit.
   -> Raise Q_READY for one cycle -> Q_VALID=0 next cycle, Q still 4'b1011.
3. LSB-first word. DIR=1, bits 1,0,1,1.
   -> Q=4'b1101.
   -> Toggling DIR after the first bit has no effect.
4. Overflow. Q_READY=0, stream 4'hA then 4'h5 MSB-first back-to-back.
   -> Q stays 4'hA and OVERFLOW=1 after the 8th bit.
   -> CLR=1 clears OVERFLOW.
   -> Repeat with Q_READY=1 in the completion cycle of the second word -> Q=4'h5, OVERFLOW stays 0.
5. Resync and reset mid-word.
   - Send S_START plus 2 bits, then S_START plus bits 0,1,1,0 (MSB-first).
     -> FRAME_ERR high exactly 1 cycle; Q=4'b0110.
   - Send 3 bits of a word, assert RESET_L=0 for one cycle, then a full word 4'h9.
     -> Q=4'h9 only.
6. ENB gating. Assert ENB=0 for 3 cycles mid-word with S_VALID=1 and S_IN toggling.
   -> Those bits are ignored; the word 4'hC completes correctly after ENB returns.
   -> A pending Q_VALID still clears on Q_READY while ENB=0.

Source files
------------

// File: rtl/deserializador_pkg.sv
// Shared types for the serial-to-parallel receiver.
// States and bit-order encodings.
package deserializador_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

endpackage

// File: rtl/deserializador_buffer_salida.sv
// Single-entry valid/ready output buffer.
// Owns the received word, its valid flag and the overflow flag.
module deserializador_buffer_salida #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] word_i,
  input  logic             done_i,
  input  logic             ready_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o,
  output logic             ovf_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             drop;

  always_comb begin
    q_d     = q_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    drop    = done_i & valid_q & ~ready_i;
    if (done_i) begin
      if (!drop) begin
        q_d     = word_i;
        valid_d = 1'b1;
      end
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
    // a fresh drop beats a simultaneous clear
    if (drop)       ovf_d = 1'b1;
    else if (clr_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q_o     = q_q;
  assign valid_o = valid_q;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/deserializador.sv
// Serial-to-parallel receiver: framing FSM, shift register
// and bit counter feeding a single-entry output buffer.
module deserializador
  import deserializador_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET_L,
  input  logic             ENB,
  input  logic             S_IN,
  input  logic             S_VALID,
  input  logic             S_START,
  input  logic             DIR,
  input  logic             CLR,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  input  logic             Q_READY,
  output logic             OVERFLOW,
  output logic             FRAME_ERR
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             ferr_q, ferr_d;

  logic             accept;
  logic             first;
  logic             dir_eff;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] sr_nx;
  logic [CW-1:0]    cnt_nx;
  logic             done;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    ferr_d  = 1'b0;
    done    = 1'b0;
    accept  = ENB & S_VALID;
    first   = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): first = accept & S_START;
      (state_q == ST_RECV): first = accept & (S_START | (cnt_q == '0));
    endcase
    dir_eff = first ? DIR : dir_q;
    base    = first ? '0 : sr_q;
    sr_nx   = base;
    unique case (dir_eff)
      DIR_MSB_FIRST: sr_nx = {base[WIDTH-2:0], S_IN};
      DIR_LSB_FIRST: sr_nx = {S_IN, base[WIDTH-1:1]};
    endcase
    cnt_nx = (first ? '0 : cnt_q) + 1'b1;
    if (first || (accept && state_q == ST_RECV)) begin
      state_d = ST_RECV;
      dir_d   = dir_eff;
      sr_d    = sr_nx;
      ferr_d  = (state_q == ST_RECV) & S_START & (cnt_q != '0);
      if (cnt_nx == CNT_FULL) begin
        done  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_nx;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_L) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_MSB_FIRST;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ferr_q  <= ferr_d;
    end
  end

  assign FRAME_ERR = ferr_q;

  deserializador_buffer_salida #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk_i   (CLK),
    .rst_ni  (RESET_L),
    .word_i  (sr_nx),
    .done_i  (done),
    .ready_i (Q_READY),
    .clr_i   (CLR),
    .q_o     (Q),
    .valid_o (Q_VALID),
    .ovf_o   (OVERFLOW)
  );

endmodule

// File: tb/tb_deserializador.sv
// Directed plus random stimulus against a bit-list
// reference model of the receiver.
module tb_deserializador;

  localparam int W = 4;

  logic         CLK = 1'b0;
  logic         RESET_L = 1'b0;
  logic         ENB = 1'b0;
  logic         S_IN = 1'b0;
  logic         S_VALID = 1'b0;
  logic         S_START = 1'b0;
  logic         DIR = 1'b0;
  logic         CLR = 1'b0;
  logic         Q_READY = 1'b0;
  logic [W-1:0] Q;
  logic         Q_VALID;
  logic         OVERFLOW;
  logic         FRAME_ERR;

  int total = 0;
  int bad = 0;

  bit       m_recv;
  bit       m_dir;
  int       m_bits[$];
  int       m_q;
  bit       m_qv;
  bit       m_ovf;
  bit       m_fe;

  always #5 CLK = ~CLK;

  deserializador #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RESET_L   (RESET_L),
    .ENB       (ENB),
    .S_IN      (S_IN),
    .S_VALID   (S_VALID),
    .S_START   (S_START),
    .DIR       (DIR),
    .CLR       (CLR),
    .Q         (Q),
    .Q_VALID   (Q_VALID),
    .Q_READY   (Q_READY),
    .OVERFLOW  (OVERFLOW),
    .FRAME_ERR (FRAME_ERR)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s @%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model(input bit rl, en, sv, ss, si, dr, cl, rd);
    bit done;
    bit drop;
    int word;
    done = 0;
    drop = 0;
    word = 0;
    m_fe = 0;
    if (!rl) begin
      m_recv = 0;
      m_dir  = 0;
      m_bits.delete();
      m_q    = 0;
      m_qv   = 0;
      m_ovf  = 0;
      return;
    end
    if (en && sv) begin
      if (!m_recv) begin
        if (ss) begin
          m_recv = 1;
          m_dir  = dr;
          m_bits.push_back(int'(si));
        end
      end else begin
        if (ss && m_bits.size() != 0) begin
          m_fe = 1;
          m_bits.delete();
        end
        if (m_bits.size() == 0) m_dir = dr;
        m_bits.push_back(int'(si));
      end
      if (m_bits.size() == W) begin
        for (int i = 0; i < W; i++) begin
          if (m_dir) word += m_bits[i] * (1 << i);
          else       word += m_bits[i] * (1 << (W - 1 - i));
        end
        done = 1;
        m_bits.delete();
      end
    end
    if (done) begin
      if (!m_qv || rd) begin
        m_q  = word;
        m_qv = 1;
      end else begin
        drop = 1;
      end
    end else if (m_qv && rd) begin
      m_qv = 0;
    end
    if (drop)    m_ovf = 1;
    else if (cl) m_ovf = 0;
  endtask

  task automatic step(input bit rl, en, sv, ss, si, dr, cl, rd);
    RESET_L = rl;
    ENB     = en;
    S_VALID = sv;
    S_START = ss;
    S_IN    = si;
    DIR     = dr;
    CLR     = cl;
    Q_READY = rd;
    @(posedge CLK);
    model(rl, en, sv, ss, si, dr, cl, rd);
    #1;
    chk("q", int'(Q), m_q);
    chk("q_valid", int'(Q_VALID), int'(m_qv));
    chk("overflow", int'(OVERFLOW), int'(m_ovf));
    chk("frame_err", int'(FRAME_ERR), int'(m_fe));
  endtask

  task automatic idle(input bit rd);
    step(1, 1, 0, 0, 0, 0, 0, rd);
  endtask

  // send W bits, first with S_START; bits given in sending order
  task automatic send(input logic [W-1:0] b, input bit dr, input bit rd_last);
    for (int i = 0; i < W; i++)
      step(1, 1, 1, i == 0, b[W-1-i], dr, 0, (i == W - 1) ? rd_last : 1'b0);
  endtask

  initial begin
    // 1: reset with busy inputs
    step(0, 1, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0, 0, 0);
    chk("rst_q", int'(Q), 0);
    chk("rst_qv", int'(Q_VALID), 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    chk("rst_rel_fe", int'(FRAME_ERR), 0);

    // 2: MSB-first and handshake
    send(4'b1011, 0, 0);
    chk("t2_q", int'(Q), 'b1011);
    chk("t2_qv", int'(Q_VALID), 1);
    idle(1);
    chk("t2_qv_clr", int'(Q_VALID), 0);
    chk("t2_q_hold", int'(Q), 'b1011);

    // 3: LSB-first, DIR toggled after first bit
    step(1, 1, 1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 1, 1, 0, 0);
    chk("t3_q", int'(Q), 'b1101);
    idle(1);

    // 4: overflow, clear, then ready on completion
    send(4'hA, 0, 0);
    send(4'h5, 0, 0);
    chk("t4_q", int'(Q), 'hA);
    chk("t4_ovf", int'(OVERFLOW), 1);
    step(1, 1, 0, 0, 0, 0, 1, 0);
    chk("t4_ovf_clr", int'(OVERFLOW), 0);
    idle(1);
    send(4'hA, 0, 0);
    send(4'h5, 0, 1);
    chk("t4_q5", int'(Q), 'h5);
    chk("t4_ovf0", int'(OVERFLOW), 0);
    idle(1);

    // 5: resync mid-word
    step(1, 1, 1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    send(4'b0110, 0, 0);
    chk("t5_q", int'(Q), 'b0110);
    idle(1);
    chk("t5_fe_gone", int'(FRAME_ERR), 0);

    // 5b: reset mid-word
    step(1, 1, 1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 1, 0, 0, 0);
    chk("t5_rst_qv", int'(Q_VALID), 0);
    send(4'h9, 0, 0);
    chk("t5_q9", int'(Q), 'h9);

    // 6: ENB gating with a pending word consumed meanwhile
    step(1, 1, 1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 1, 0, 1);
    chk("t6_qv_clr", int'(Q_VALID), 0);
    step(1, 0, 1, 0, 1, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0, 0);
    chk("t6_q", int'(Q), 'hC);
    chk("t6_qv", int'(Q_VALID), 1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 199) != 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 9) == 0,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           $urandom_range(0, 15) == 0,
           1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
